// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and exec mask, fetches one word at a time
// and hands {pc, insn, mask} packets to decode. INIT_FETCH_COUNT sets the reset value of fetch_count (default 0).
module fetch_stage #(
  parameter int                CORE_ID          = 0,
  parameter logic [63:0]       RESET_PC         = 64'h0,
  parameter int                MASK_W           = 8,
  parameter logic [MASK_W-1:0] RESET_MASK       = '1,
  parameter logic [31:0]       INIT_FETCH_COUNT = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [63:0]       mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [63:0]       dec_pc,
  output logic [31:0]       dec_insn,
  output logic [MASK_W-1:0] dec_exec_mask,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  input  logic [MASK_W-1:0] redirect_mask,
  input  logic              halt,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_SEND, S_HALTED} state_t;

  state_t            r_state, w_state_nx;
  logic [63:0]       r_pc, w_pc_nx;
  logic [MASK_W-1:0] r_mask, w_mask_nx;
  logic [31:0]       r_insn, w_insn_nx;
  logic              r_squash, w_squash_nx;
  logic [31:0]       r_fetch_count, w_count_nx;
  logic              r_live;
  logic              w_req_fire;

  // r_live keeps the request low for the reset cycle even though state is REQ.
  assign mem_req_valid = r_live && (r_state == S_REQ);
  assign mem_req_addr  = r_pc;
  assign dec_valid     = (r_state == S_SEND);
  assign dec_pc        = dec_valid ? r_pc   : '0;
  assign dec_insn      = dec_valid ? r_insn : '0;
  assign dec_exec_mask = dec_valid ? r_mask : '0;
  assign halted        = (r_state == S_HALTED);
  assign fetch_count   = r_fetch_count;
  assign w_req_fire    = mem_req_valid && mem_req_ready;

  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_mask_nx   = r_mask;
    w_insn_nx   = r_insn;
    w_squash_nx = r_squash;
    w_count_nx  = r_fetch_count;
    unique case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_nx   = redirect_pc;
          w_mask_nx = redirect_mask;
        end
        if (w_req_fire) begin
          w_state_nx  = S_WAIT;
          w_squash_nx = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nx   = redirect_pc;
          w_mask_nx = redirect_mask;
        end
        if (mem_rsp_valid) begin
          if (r_squash || redirect_valid) begin
            w_state_nx  = S_REQ;
            w_squash_nx = 1'b0;
          end else begin
            w_insn_nx  = mem_rsp_data;
            w_state_nx = S_SEND;
          end
        end else if (redirect_valid) begin
          w_squash_nx = 1'b1;
        end
      end
      S_SEND: begin
        if (dec_ready) begin
          w_count_nx = r_fetch_count + 32'd1;
          w_pc_nx    = redirect_valid ? redirect_pc : r_pc + 64'd4;
          if (redirect_valid) w_mask_nx = redirect_mask;
          w_state_nx = S_REQ;
        end else if (redirect_valid) begin
          w_pc_nx    = redirect_pc;
          w_mask_nx  = redirect_mask;
          w_state_nx = S_REQ;
        end
      end
      S_HALTED: begin
      end
    endcase
    // Halt wins over redirect, but a transfer in the same cycle still counts.
    if (halt && (r_state != S_HALTED)) begin
      w_state_nx  = S_HALTED;
      w_pc_nx     = r_pc;
      w_mask_nx   = r_mask;
      w_squash_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_mask        <= RESET_MASK;
      r_insn        <= '0;
      r_squash      <= 1'b0;
      r_fetch_count <= INIT_FETCH_COUNT;
      r_live        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_pc          <= w_pc_nx;
      r_mask        <= w_mask_nx;
      r_insn        <= w_insn_nx;
      r_squash      <= w_squash_nx;
      r_fetch_count <= w_count_nx;
      r_live        <= 1'b1;
    end
  end

  a_rsp_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rsp_valid |-> (r_state == S_WAIT || r_state == S_HALTED))
    else $error("fetch_stage[%0d]: mem_rsp_valid with no request outstanding", CORE_ID);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance at RESET_PC=0x100, second instance
// preloaded near the PC / fetch_count wrap points.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid;
  logic [63:0] req_addr;
  logic [31:0] rsp_data;
  logic        dvalid, dready;
  logic [63:0] dpc;
  logic [31:0] dinsn;
  logic [7:0]  dmask;
  logic        rd_valid;
  logic [63:0] rd_pc;
  logic [7:0]  rd_mask;
  logic        hlt, hlted;
  logic [31:0] fcount;

  logic        w_req_valid, w_req_ready, w_rsp_valid;
  logic [63:0] w_req_addr;
  logic [31:0] w_rsp_data;
  logic        w_dvalid, w_dready;
  logic [63:0] w_dpc;
  logic [31:0] w_dinsn;
  logic [7:0]  w_dmask;
  logic        w_hlted;
  logic [31:0] w_fcount;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage #(.CORE_ID(0), .RESET_PC(64'h100), .MASK_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_addr(req_addr),
    .mem_rsp_valid(rsp_valid), .mem_rsp_data(rsp_data),
    .dec_valid(dvalid), .dec_ready(dready), .dec_pc(dpc), .dec_insn(dinsn),
    .dec_exec_mask(dmask),
    .redirect_valid(rd_valid), .redirect_pc(rd_pc), .redirect_mask(rd_mask),
    .halt(hlt), .halted(hlted), .fetch_count(fcount)
  );

  fetch_stage #(.CORE_ID(1), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .MASK_W(8),
                .INIT_FETCH_COUNT(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(w_req_valid), .mem_req_ready(w_req_ready), .mem_req_addr(w_req_addr),
    .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
    .dec_valid(w_dvalid), .dec_ready(w_dready), .dec_pc(w_dpc), .dec_insn(w_dinsn),
    .dec_exec_mask(w_dmask),
    .redirect_valid(1'b0), .redirect_pc(64'h0), .redirect_mask(8'h0),
    .halt(1'b0), .halted(w_hlted), .fetch_count(w_fcount)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with the stage in REQ and mem_req_ready=1; leaves it in REQ at the next PC.
  task automatic run_fetch(input logic [31:0] word, input logic [63:0] pc, input logic [7:0] mask);
    check("req_addr", req_addr, pc);
    check("req_valid", req_valid, 1'b1);
    tick();
    rsp_valid = 1'b1;
    rsp_data  = word;
    check("wait_req_valid", req_valid, 1'b0);
    tick();
    rsp_valid = 1'b0;
    check("dec_valid", dvalid, 1'b1);
    check("dec_pc", dpc, pc);
    check("dec_insn", dinsn, word);
    check("dec_mask", dmask, mask);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    dready = 1'b0; rd_valid = 1'b0; rd_pc = '0; rd_mask = '0; hlt = 1'b0;
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0; w_dready = 1'b0;
    tick();
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_dec_valid", dvalid, 1'b0);
    check("rst_halted", hlted, 1'b0);
    check("rst_dec_pc", dpc, 64'h0);
    check("rst_count", fcount, 32'h0);
    tick();
    check("rst_req_valid_held", req_valid, 1'b0);
    rst_n = 1'b1; req_ready = 1'b1; dready = 1'b1;
    tick();

    // Straight-line fetch
    run_fetch(32'h1122_3344, 64'h100, 8'hFF);
    run_fetch(32'h1122_3344, 64'h104, 8'hFF);
    run_fetch(32'h1122_3344, 64'h108, 8'hFF);
    check("count_after_3", fcount, 32'd3);

    // Backpressure
    dready = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp_data = 32'hA5A5_0001;
    tick();
    rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_dec_valid", dvalid, 1'b1);
      check("bp_dec_pc", dpc, 64'h10C);
      check("bp_dec_insn", dinsn, 32'hA5A5_0001);
      check("bp_req_valid", req_valid, 1'b0);
      tick();
    end
    dready = 1'b1;
    tick();
    check("bp_done_dec_valid", dvalid, 1'b0);
    check("bp_done_count", fcount, 32'd4);
    check("bp_done_req_valid", req_valid, 1'b1);
    check("bp_done_addr", req_addr, 64'h110);

    // Squashed fetch: redirect during WAIT, stale word two cycles later
    tick();
    rd_valid = 1'b1; rd_pc = 64'h400; rd_mask = 8'h0F;
    tick();
    rd_valid = 1'b0;
    check("sq_req_valid", req_valid, 1'b0);
    check("sq_dec_valid", dvalid, 1'b0);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h0000_DEAD;
    tick();
    rsp_valid = 1'b0;
    check("sq_drop_dec_valid", dvalid, 1'b0);
    check("sq_next_addr", req_addr, 64'h400);
    run_fetch(32'hCAFE_0400, 64'h400, 8'h0F);
    check("sq_count", fcount, 32'd5);

    // Redirect in REQ without handshake, then redirect together with dec_ready
    req_ready = 1'b0; rd_valid = 1'b1; rd_pc = 64'h200; rd_mask = 8'h33;
    tick();
    rd_valid = 1'b0; req_ready = 1'b1; dready = 1'b0;
    check("req_redir_valid", req_valid, 1'b1);
    check("req_redir_addr", req_addr, 64'h200);
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h0BAD_F00D;
    tick();
    rsp_valid = 1'b0;
    check("sim_dec_pc", dpc, 64'h200);
    check("sim_dec_mask", dmask, 8'h33);
    dready = 1'b1; rd_valid = 1'b1; rd_pc = 64'h800; rd_mask = 8'hF0;
    tick();
    rd_valid = 1'b0;
    check("sim_dec_valid", dvalid, 1'b0);
    check("sim_count", fcount, 32'd6);
    check("sim_next_addr", req_addr, 64'h800);

    // Redirect together with the request handshake
    rd_valid = 1'b1; rd_pc = 64'h900; rd_mask = 8'h3C;
    tick();
    rd_valid = 1'b0;
    check("hs_redir_wait", req_valid, 1'b0);
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_0800;
    tick();
    rsp_valid = 1'b0;
    check("hs_redir_dec_valid", dvalid, 1'b0);
    check("hs_redir_req_valid", req_valid, 1'b1);
    check("hs_redir_addr", req_addr, 64'h900);

    // Redirect in SEND without dec_ready retracts the packet
    dready = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
    tick();
    rsp_valid = 1'b0;
    check("rt_dec_valid", dvalid, 1'b1);
    check("rt_dec_mask", dmask, 8'h3C);
    rd_valid = 1'b1; rd_pc = 64'hA00; rd_mask = 8'hFF;
    tick();
    rd_valid = 1'b0;
    check("rt_retracted", dvalid, 1'b0);
    check("rt_addr", req_addr, 64'hA00);
    check("rt_count", fcount, 32'd6);

    // Halt together with redirect
    req_ready = 1'b0; hlt = 1'b1; rd_valid = 1'b1; rd_pc = 64'hB00;
    tick();
    hlt = 1'b0; rd_valid = 1'b0;
    check("halt_halted", hlted, 1'b1);
    check("halt_req_valid", req_valid, 1'b0);
    rd_valid = 1'b1; rd_pc = 64'hC00; req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_stays", hlted, 1'b1);
      check("halt_no_req", req_valid, 1'b0);
      check("halt_addr", req_addr, 64'hA00);
    end
    rd_valid = 1'b0;

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_halted", hlted, 1'b0);
    check("arst_req_valid", req_valid, 1'b0);
    check("arst_count", fcount, 32'd0);
    check("arst_addr", req_addr, 64'h100);
    #1;
    rst_n = 1'b1;
    req_ready = 1'b0;
    tick();
    check("arst_rel_req_valid", req_valid, 1'b1);
    check("arst_rel_addr", req_addr, 64'h100);

    // Wrap of pc and fetch_count
    check("wrap_rst_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    w_req_ready = 1'b1; w_dready = 1'b1;
    tick();
    w_rsp_valid = 1'b1; w_rsp_data = 32'h600D_C0DE;
    tick();
    w_rsp_valid = 1'b0;
    check("wrap_dec_pc", w_dpc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_dec_insn", w_dinsn, 32'h600D_C0DE);
    tick();
    check("wrap_addr", w_req_addr, 64'h0);
    check("wrap_count", w_fcount, 32'h0);
    check("wrap_req_valid", w_req_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for one core, directly upstream of decode. It holds the program counter and the active execution mask, and reads one 32-bit instruction word at a time from the instruction memory port. Each word is delivered to decode as a {PC, insn, exec_mask} packet over a valid/ready handshake. Execute can redirect the PC (jumps, restores) or halt the stage; stale wrong-path fetches are squashed.

## Interface
- CORE_ID, 0: core index, reported in `$display` trace only.
- RESET_PC, 64'h0: PC loaded at reset.
- MASK_W, 8: execution-mask width (one bit per vector lane).
- RESET_MASK, all-ones: exec mask loaded at reset.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  async active-low reset.
- mem_req_valid  out  1  fetch request pending.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  64  byte address equal to the current PC.
- mem_rsp_valid  in  1  instruction word returned; always accepted, no ready.
- mem_rsp_data  in  32  instruction word.
- dec_valid  out  1  packet available to decode.
- dec_ready  in  1  decode accepts the packet (decode not busy).
- dec_pc  out  64  PC of the packet.
- dec_insn  out  32  instruction word.
- dec_exec_mask  out  MASK_W  lane mask for the packet.
- redirect_valid  in  1  execute redirects fetch.
- redirect_pc  in  64  new PC.
- redirect_mask  in  MASK_W  new exec mask.
- halt  in  1  execute saw HALT; stop fetching.
- halted  out  1  stage is in HALTED.
- fetch_count  out  32  packets delivered to decode; wraps at 2^32.

## Operation
- The FSM has four states: REQ, WAIT, SEND, HALTED. Registers: pc, mask, insn_q, squash, fetch_count.
- **REQ**
  - mem_req_valid=1, mem_req_addr=pc.
  - On mem_req_ready, go to WAIT.
- **WAIT**
  - On mem_rsp_valid with squash=0: latch insn_q, go to SEND.
  - On mem_rsp_valid with squash=1: drop the word, clear squash, go to REQ.
- **SEND**
  - dec_valid=1; dec_pc/insn/exec_mask are stable until transfer.
  - On dec_ready: increment fetch_count, pc←pc+4, go to REQ.
- **HALTED**
  - All outputs are idle; only reset exits this state.
- **Redirect** (redirect_valid=1) has priority over PC increment. pc←redirect_pc and mask←redirect_mask in all states except HALTED, where it is ignored.
  - REQ without handshake: address changes next cycle. mem_req_addr may change only under redirect.
  - REQ with handshake in the same cycle: go to WAIT with squash=1.
  - WAIT: set squash=1. If mem_rsp_valid arrives in the same cycle, drop that word and go directly to REQ with squash=0.
  - SEND without dec_ready: retract the packet (dec_valid=0 next cycle), go to REQ.
  - SEND with dec_ready in the same cycle: the transfer completes and counts, but pc takes redirect_pc, not pc+4.
- **Halt**, from any state:
  - Enter HALTED next cycle.
  - It dominates redirect.
  - A packet transferring in the same cycle still counts.
  - Any outstanding response is ignored.
- pc arithmetic is 64-bit unsigned and wraps modulo 2^64; no alignment check.

## Timing
- **Reset values:** state=REQ, pc=RESET_PC, mask=RESET_MASK, squash=0, fetch_count=0. Outputs: mem_req_valid=0 while rst_n=0, then 1 from the first edge after release. dec_valid=0, halted=0, dec_* outputs=0.
- **Asynchronous reset mid-operation:** returns to the reset values immediately. The memory port shares rst_n, so no response is outstanding after reset.
- **Minimum rate:** 3 cycles per instruction with single-cycle memory (REQ, WAIT, SEND). With one cycle of response latency, the first dec_valid appears on the 3rd edge after reset release.
- **Outstanding requests:** at most one.
- **Handshake outputs:** registered. dec_valid never depends combinationally on dec_ready.
- **Redirect latency:** the first request at the redirected PC appears on the cycle after redirect, or after the squashed response drains.
- **Assertions:** mem_rsp_valid outside WAIT is illegal and must fire an assertion.

## Test plan
- **Straight-line fetch.** Reset with RESET_PC=0x100, memory returns 0x11223344 after 1 cycle, dec_ready=1. Expect:
  - dec_pc 0x100, 0x104, 0x108, each every 3 cycles.
  - fetch_count=3 after 3 packets.
- **Backpressure.** Hold dec_ready=0 for 5 cycles in SEND. Expect:
  - dec_valid, dec_pc and dec_insn stable throughout.
  - No new mem_req_valid until the transfer completes.
- **Squashed fetch.** Redirect to 0x400 with mask 0x0F during WAIT; stale response 0xDEAD arrives 2 cycles later. Expect:
  - The stale word is never presented to decode.
  - Next request addr=0x400.
  - Packet carries exec_mask=0x0F.
- **Simultaneous events.** Assert redirect together with dec_ready in SEND (pc=0x200, target 0x800). Expect:
  - The packet at 0x200 is delivered and fetch_count increments.
  - Next mem_req_addr=0x800.
- **Halt with redirect.** Assert halt together with redirect. Expect:
  - halted=1 next cycle.
  - mem_req_valid=0 permanently; later redirects are ignored.
  - Async reset restores REQ at RESET_PC.
- **Wrap.** Preload pc=0xFFFF_FFFF_FFFF_FFFC and fetch_count=0xFFFF_FFFF, then complete one transfer. Expect next addr=0x0 and fetch_count=0.
